// File: rtl/restoring_div_ctrl.sv
// restoring_div_ctrl: control FSM for a W=SIZE+1 bit restoring divider; define RESTORING_DIV_DZ_CHECK_EN for divide-by-zero trapping.
module restoring_div_ctrl #(
  parameter int SIZE  = 6,
  parameter int CNT_W = $clog2(SIZE + 2)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic sub_neg,
  input  logic divisor_zero,
  output logic ld_q,
  output logic ld_b,
  output logic clr_a,
  output logic shl_aq,
  output logic ld_a_diff,
  output logic set_q0,
  output logic ready,
  output logic busy,
  output logic done,
  output logic dz_err
);
  typedef enum logic [2:0] {IDLE, INIT, CHK, SHIFT, SUB, DONE, ERR} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] count;
  logic dz_go;
`ifdef RESTORING_DIV_DZ_CHECK_EN
  assign dz_go  = divisor_zero;
  assign dz_err = state == ERR;
`else
  logic unused_dz;
  assign unused_dz = divisor_zero;
  assign dz_go     = 1'b0;
  assign dz_err    = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= nxt;
      count <= state == INIT ? '0 : state == SUB ? count + 1'b1 : count;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? INIT : IDLE;
      INIT:    nxt = CHK;
      CHK:     nxt = dz_go ? ERR : SHIFT;
      SHIFT:   nxt = SUB;
      SUB:     nxt = count == CNT_W'(SIZE) ? DONE : SHIFT;
      default: nxt = IDLE;
    endcase
  end
  // quotient bit and A reload are Mealy on the datapath sign during SUB
  always_comb begin
    ld_q      = state == INIT;
    ld_b      = state == INIT;
    clr_a     = state == INIT;
    shl_aq    = state == SHIFT;
    ld_a_diff = state == SUB && !sub_neg;
    set_q0    = state == SUB && !sub_neg;
    ready     = state == IDLE;
    busy      = state == INIT || state == SHIFT || state == SUB;
    done      = state == DONE || state == ERR;
  end
endmodule

// File: tb/tb_restoring_div_ctrl.sv
// tb_restoring_div_ctrl: directed bench with a behavioural A/Q/B datapath model around the divider control.
module tb_restoring_div_ctrl;
  logic clk = 0, rst = 1, start = 0;
  logic sub_neg, divisor_zero;
  logic ld_q, ld_b, clr_a, shl_aq, ld_a_diff, set_q0, ready, busy, done, dz_err;
  logic [6:0] dividend = 0, divisor = 0, ma = 0, mq = 0, mb = 0;
  int total = 0, bad = 0;
  int done_k, ndone, ndz, nldq, nshl, ndiff, excl, init2, rdy_after;
  logic [6:0] mask, rq, ra;

  always #5 clk = ~clk;

  restoring_div_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .sub_neg(sub_neg), .divisor_zero(divisor_zero),
    .ld_q(ld_q), .ld_b(ld_b), .clr_a(clr_a), .shl_aq(shl_aq), .ld_a_diff(ld_a_diff),
    .set_q0(set_q0), .ready(ready), .busy(busy), .done(done), .dz_err(dz_err)
  );

  assign sub_neg      = ma < mb;
  assign divisor_zero = mb == 0;

  always @(posedge clk) begin
    if (clr_a) ma <= 0;
    else if (shl_aq) ma <= {ma[5:0], mq[6]};
    else if (ld_a_diff) ma <= ma - mb;
    if (ld_q) mq <= dividend;
    else if (shl_aq) mq <= {mq[5:0], 1'b0};
    else if (set_q0) mq[0] <= 1'b1;
    if (ld_b) mb <= divisor;
  end

  task automatic do_reset();
    start = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  // Start a divide and observe 30 cycles; cycle k follows the k-th edge after start is sampled.
  task automatic run(input logic [6:0] dvd, input logic [6:0] dvs, input bit hold, input bit pulse);
    bit prev_shl = 0;
    int sub_i = 0;
    dividend = dvd; divisor = dvs;
    done_k = 0; ndone = 0; ndz = 0; nldq = 0; nshl = 0; ndiff = 0; excl = 0; init2 = 0;
    rdy_after = 0; mask = 0; rq = 'x; ra = 'x;
    @(negedge clk); start = 1;
    @(negedge clk); if (!hold) start = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k > 1) @(negedge clk);
      if (done_k != 0 && k == done_k + 1) rdy_after = ready;
      if (done && done_k == 0) begin done_k = k; rq = mq; ra = ma; end
      if (done) ndone++;
      if (dz_err) ndz++;
      if (ld_q) begin nldq++; if (k > 1 && init2 == 0) init2 = k; end
      if (shl_aq) nshl++;
      if (ld_a_diff) ndiff++;
      if (int'(ld_q) + int'(shl_aq) + int'(ld_a_diff) > 1) excl++;
      if (prev_shl) begin
        if (set_q0 && sub_i < 7) mask[sub_i] = 1'b1;
        sub_i++;
      end
      prev_shl = shl_aq;
      if (pulse) start = (k == 5 || k == 10);
    end
    start = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({ready, busy} !== 2'b10) begin bad++; $display("FAIL reset_idle ready/busy=%b want 10", {ready, busy}); end
    total++; if ({ld_q, ld_b, clr_a, shl_aq, ld_a_diff, set_q0, done, dz_err} !== 8'h0) begin bad++;
      $display("FAIL reset_ctrl got %b want 0", {ld_q, ld_b, clr_a, shl_aq, ld_a_diff, set_q0, done, dz_err}); end
    dividend = 45; divisor = 6;
    start = 1; @(negedge clk); start = 0;
    repeat (6) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got %b want 1", busy); end
    rst = 1; repeat (2) @(negedge clk); rst = 0;
    @(negedge clk);
    total++; if ({ready, busy} !== 2'b10) begin bad++; $display("FAIL abort_idle ready/busy=%b want 10", {ready, busy}); end
    total++; if ({ld_q, ld_b, clr_a, shl_aq, ld_a_diff, set_q0, done, dz_err} !== 8'h0) begin bad++;
      $display("FAIL abort_ctrl got %b want 0", {ld_q, ld_b, clr_a, shl_aq, ld_a_diff, set_q0, done, dz_err}); end
  endtask

  task automatic test_div_45_6();
    do_reset();
    run(45, 6, 0, 0);
    total++; if (done_k !== 17) begin bad++; $display("FAIL d45_latency got %0d want 17", done_k); end
    total++; if (mask !== 7'b1110000) begin bad++; $display("FAIL d45_setq0 got %b want 1110000", mask); end
    total++; if (rq !== 7) begin bad++; $display("FAIL d45_q got %0d want 7", rq); end
    total++; if (ra !== 3) begin bad++; $display("FAIL d45_a got %0d want 3", ra); end
    total++; if (ndone !== 1) begin bad++; $display("FAIL d45_done_pulses got %0d want 1", ndone); end
    total++; if (rdy_after !== 1) begin bad++; $display("FAIL d45_ready_after got %0d want 1", rdy_after); end
    total++; if (excl !== 0) begin bad++; $display("FAIL d45_exclusive got %0d want 0", excl); end
    total++; if (nshl !== 7) begin bad++; $display("FAIL d45_shifts got %0d want 7", nshl); end
  endtask

  task automatic test_div_127_1();
    do_reset();
    run(127, 1, 0, 0);
    total++; if (mask !== 7'h7F) begin bad++; $display("FAIL d127_setq0 got %b want 1111111", mask); end
    total++; if (rq !== 127) begin bad++; $display("FAIL d127_q got %0d want 127", rq); end
    total++; if (ra !== 0) begin bad++; $display("FAIL d127_a got %0d want 0", ra); end
    total++; if (ndiff !== 7) begin bad++; $display("FAIL d127_ldiff got %0d want 7", ndiff); end
  endtask

  task automatic test_div_3_5();
    do_reset();
    run(3, 5, 0, 0);
    total++; if (ndiff !== 0) begin bad++; $display("FAIL d3_ldiff got %0d want 0", ndiff); end
    total++; if (rq !== 0) begin bad++; $display("FAIL d3_q got %0d want 0", rq); end
    total++; if (ra !== 3) begin bad++; $display("FAIL d3_a got %0d want 3", ra); end
    total++; if (done_k !== 17) begin bad++; $display("FAIL d3_latency got %0d want 17", done_k); end
  endtask

  task automatic test_divisor_zero();
    do_reset();
    run(45, 0, 0, 0);
`ifdef RESTORING_DIV_DZ_CHECK_EN
    total++; if (done_k !== 3) begin bad++; $display("FAIL dz_latency got %0d want 3", done_k); end
    total++; if (ndz !== 1) begin bad++; $display("FAIL dz_err_pulses got %0d want 1", ndz); end
    total++; if (nshl !== 0) begin bad++; $display("FAIL dz_shifts got %0d want 0", nshl); end
`else
    total++; if (done_k !== 17) begin bad++; $display("FAIL dz_latency got %0d want 17", done_k); end
    total++; if (rq !== 7'h7F) begin bad++; $display("FAIL dz_q got %h want 7f", rq); end
    total++; if (ra !== 45) begin bad++; $display("FAIL dz_a got %0d want 45", ra); end
    total++; if (ndz !== 0) begin bad++; $display("FAIL dz_err_pulses got %0d want 0", ndz); end
`endif
  endtask

  task automatic test_start_ignored();
    do_reset();
    run(45, 6, 0, 1);
    total++; if (ndone !== 1) begin bad++; $display("FAIL ign_done_pulses got %0d want 1", ndone); end
    total++; if (nldq !== 1) begin bad++; $display("FAIL ign_inits got %0d want 1", nldq); end
    total++; if (done_k !== 17) begin bad++; $display("FAIL ign_latency got %0d want 17", done_k); end
    total++; if (ready !== 1) begin bad++; $display("FAIL ign_idle got %b want 1", ready); end
    run(20, 3, 0, 0);
    total++; if (rq !== 6) begin bad++; $display("FAIL ign_next_q got %0d want 6", rq); end
    total++; if (ra !== 2) begin bad++; $display("FAIL ign_next_a got %0d want 2", ra); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run(45, 6, 1, 0);
    total++; if (done_k !== 17) begin bad++; $display("FAIL b2b_latency got %0d want 17", done_k); end
    total++; if (init2 !== 19) begin bad++; $display("FAIL b2b_next_init got %0d want 19", init2); end
  endtask

  initial begin
    test_reset();
    test_div_45_6();
    test_div_127_1();
    test_div_3_5();
    test_divisor_zero();
    test_start_ignored();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
